// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
//   Self-synchronising PRBS7 (x^7 + x^6 + 1) checker for the recovered bit
//   stream coming out of the clock/data recovery block. It locks onto the
//   pattern, then counts checked bits and bit errors for BER measurement.
//   Losing lock is decided per error window, so a burst of errors forces a
//   resync while sparse errors are simply counted.
//
// Ports
//   clk_x8      in   oversampled system clock (same clock as the CDR)
//   rst         in   asynchronous, active-high reset
//   d_in        in   recovered data bit
//   d_in_valid  in   d_in carries a new bit this cycle (1-cycle strobe)
//   clr_counts  in   synchronous clear of bit_count / err_count
//   locked      out  1 while the checker is locked to the sequence
//   err_pulse   out  1-cycle pulse per errored bit seen while locked
//   bit_count   out  bits checked while locked (saturating)
//   err_count   out  errored bits while locked (saturating)
// -----------------------------------------------------------------------------
module prbs_checker #(
    parameter int LOCK_THRESH = 32,
    parameter int WIN         = 128,
    parameter int ERR_LIMIT   = 8,
    parameter int CNT_W       = 32
) (
    input  logic             clk_x8,
    input  logic             rst,
    input  logic             d_in,
    input  logic             d_in_valid,
    input  logic             clr_counts,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int MW = $clog2(LOCK_THRESH + 1);
    localparam int WW = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int EW = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       hist_q, hist_d;
    logic [2:0]       fill_q, fill_d;
    logic [MW-1:0]    match_q, match_d;
    logic [WW-1:0]    win_cnt_q, win_cnt_d;
    logic [EW-1:0]    win_err_q, win_err_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic             pred;
    logic             err;
    logic             win_wrap;
    logic [EW-1:0]    win_base;
    logic [EW-1:0]    win_sum;
    logic             bit_inc;
    logic             err_inc;

    // hist[6] is the bit 7 back, hist[5] the bit 6 back.
    assign pred     = hist_q[6] ^ hist_q[5];
    assign err      = (d_in != pred);
    // The bit that wraps the window counter belongs to the new window, so its
    // error is judged against an empty error count.
    assign win_wrap = (win_cnt_q == WW'(WIN - 1));
    assign win_base = win_wrap ? '0 : win_err_q;
    assign win_sum  = win_base + EW'(err);

    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_pulse_d = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;

        if (d_in_valid) begin
            case (state_q)
                ST_FILL: begin
                    hist_d = {hist_q[5:0], d_in};
                    if (fill_q == 3'd6) begin
                        fill_d  = '0;
                        match_d = '0;
                        state_d = ST_SEARCH;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_SEARCH: begin
                    hist_d = {hist_q[5:0], d_in};
                    // A zero history predicts zero forever, so it must not
                    // count as a match or the all-zero stream would lock.
                    if ((d_in == pred) && (hist_q != 7'h00)) begin
                        if (match_q == MW'(LOCK_THRESH - 1)) begin
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                            state_d   = ST_LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    bit_inc     = 1'b1;
                    err_inc     = err;
                    err_pulse_d = err;
                    if (win_sum == EW'(ERR_LIMIT)) begin
                        state_d   = ST_FILL;
                        hist_d    = '0;
                        fill_d    = '0;
                        match_d   = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        // Free-run on the prediction so a flipped input bit
                        // never pollutes the history (one flip = one error).
                        hist_d    = {hist_q[5:0], pred};
                        win_cnt_d = win_wrap ? '0 : (win_cnt_q + WW'(1));
                        win_err_d = win_sum;
                    end
                end
                default: begin
                    state_d = ST_FILL;
                end
            endcase
        end

        locked_d = (state_d == ST_LOCKED);

        // Clear has priority over a coincident increment.
        bit_cnt_d = bit_cnt_q;
        err_cnt_d = err_cnt_q;
        if (clr_counts) begin
            bit_cnt_d = '0;
            err_cnt_d = '0;
        end else begin
            if (bit_inc && (bit_cnt_q != '1)) begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
            if (err_inc && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_x8 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign bit_count = bit_cnt_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

    logic        clk_x8 = 1'b0;
    logic        clk_run = 1'b0;
    logic        rst = 1'b0;
    logic        d_in = 1'b0;
    logic        d_in_valid = 1'b0;
    logic        clr_counts = 1'b0;
    logic        locked;
    logic        err_pulse;
    logic [31:0] bit_count;
    logic [31:0] err_count;

    prbs_checker dut (
        .clk_x8     (clk_x8),
        .rst        (rst),
        .d_in       (d_in),
        .d_in_valid (d_in_valid),
        .clr_counts (clr_counts),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .bit_count  (bit_count),
        .err_count  (err_count)
    );

    initial begin
        wait (clk_run);
        forever #5 clk_x8 = ~clk_x8;
    end

    int total = 0;
    int bad = 0;
    int pulses = 0;
    bit seen_lock = 1'b0;
    logic [6:0] gen = 7'h7F;

    typedef struct {
        int    n;
        bit    inv;
        bit    clr_before;
        bit    exp_locked;
        int    exp_bits;
        int    exp_errs;
        int    exp_pulses;
        string name;
    } seg_t;

    seg_t segs[10];

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    // Reference PRBS7 generator: out = s[6]^s[5], shifted in as newest bit.
    task automatic next_prbs(output logic b);
        b   = gen[6] ^ gen[5];
        gen = {gen[5:0], b};
    endtask

    task automatic sample();
        pulses += int'(err_pulse);
        if (locked) seen_lock = 1'b1;
    endtask

    // One valid strobe per 8 clocks; d_in toggles randomly while not valid.
    task automatic send_bit(input logic b, input logic clr);
        @(posedge clk_x8); #1;
        d_in       = b;
        d_in_valid = 1'b1;
        clr_counts = clr;
        @(posedge clk_x8); #1;
        d_in_valid = 1'b0;
        clr_counts = 1'b0;
        d_in       = 1'($urandom);
        sample();
        repeat (6) begin
            @(posedge clk_x8); #1;
            d_in = 1'($urandom);
            sample();
        end
    endtask

    task automatic send_prbs(input int n, input bit inv);
        logic b;
        for (int k = 0; k < n; k++) begin
            next_prbs(b);
            send_bit(b ^ inv, 1'b0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk_x8); #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        logic b;

        // Clean lock, long clean run, single error, burst loss and relock.
        segs[0] = '{38,   1'b0, 1'b0, 1'b0, 0,    0, 0, "before_lock_bit38"};
        segs[1] = '{1,    1'b0, 1'b0, 1'b1, 0,    0, 0, "lock_at_bit39"};
        segs[2] = '{1000, 1'b0, 1'b0, 1'b1, 1000, 0, 0, "clean_1000"};
        segs[3] = '{1,    1'b1, 1'b0, 1'b1, 1001, 1, 1, "single_flip"};
        segs[4] = '{40,   1'b0, 1'b0, 1'b1, 1041, 1, 0, "clean_after_flip"};
        segs[5] = '{7,    1'b1, 1'b1, 1'b1, 7,    7, 7, "burst_7_errors"};
        segs[6] = '{1,    1'b1, 1'b0, 1'b0, 8,    8, 1, "burst_8th_error"};
        segs[7] = '{38,   1'b0, 1'b0, 1'b0, 8,    8, 0, "relock_bit38"};
        segs[8] = '{1,    1'b0, 1'b0, 1'b1, 8,    8, 0, "relock_bit39"};
        segs[9] = '{10,   1'b0, 1'b0, 1'b1, 18,   8, 0, "clean_after_relock"};

        // Reset with no clock edges at all.
        rst = 1'b1;
        #3;
        check("rst_locked", longint'(locked), 0);
        check("rst_err_pulse", longint'(err_pulse), 0);
        check("rst_bit_count", longint'(bit_count), 0);
        check("rst_err_count", longint'(err_count), 0);
        rst = 1'b0;
        #2;
        clk_run = 1'b1;

        gen = 7'h7F;
        for (int i = 0; i < 10; i++) begin
            if (segs[i].clr_before) begin
                @(posedge clk_x8); #1;
                clr_counts = 1'b1;
                @(posedge clk_x8); #1;
                clr_counts = 1'b0;
            end
            pulses = 0;
            send_prbs(segs[i].n, segs[i].inv);
            check({segs[i].name, "_locked"}, longint'(locked), longint'(segs[i].exp_locked));
            check({segs[i].name, "_bits"}, longint'(bit_count), longint'(segs[i].exp_bits));
            check({segs[i].name, "_errs"}, longint'(err_count), longint'(segs[i].exp_errs));
            check({segs[i].name, "_pulses"}, longint'(pulses), longint'(segs[i].exp_pulses));
        end

        // Constant-0 stream never locks.
        pulse_reset();
        seen_lock = 1'b0;
        for (int k = 0; k < 300; k++) send_bit(1'b0, 1'b0);
        check("zeros_seen_lock", longint'(seen_lock), 0);
        check("zeros_bit_count", longint'(bit_count), 0);

        // Constant-1 stream never locks.
        pulse_reset();
        seen_lock = 1'b0;
        for (int k = 0; k < 300; k++) send_bit(1'b1, 1'b0);
        check("ones_seen_lock", longint'(seen_lock), 0);
        check("ones_bit_count", longint'(bit_count), 0);

        // clr_counts coinciding with an errored bit while locked.
        pulse_reset();
        gen = 7'h7F;
        send_prbs(39, 1'b0);
        check("clr_pre_locked", longint'(locked), 1);
        send_prbs(5, 1'b0);
        check("clr_pre_bits", longint'(bit_count), 5);
        pulses = 0;
        next_prbs(b);
        send_bit(~b, 1'b1);
        check("clr_bits", longint'(bit_count), 0);
        check("clr_errs", longint'(err_count), 0);
        check("clr_locked", longint'(locked), 1);
        check("clr_err_pulse", longint'(pulses), 1);

        // Asynchronous reset mid-lock clears outputs without a clock edge.
        send_prbs(3, 1'b0);
        check("midrst_pre_bits", longint'(bit_count), 3);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_locked", longint'(locked), 0);
        check("midrst_err_pulse", longint'(err_pulse), 0);
        check("midrst_bits", longint'(bit_count), 0);
        check("midrst_errs", longint'(err_count), 0);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk_x8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
